// File: rtl/cordic_pair_collector.sv
// Pairs consecutive CORDIC results for the final adder stage.
// Drops words arriving while a pair is held and flags lone results.
module cordic_pair_collector #(
  parameter int CORDIC_DATA_WIDTH = 22,
  parameter int FLOAT_DATA_WIDTH  = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clk_en,
  input  logic [CORDIC_DATA_WIDTH-1:0] result_in,
  input  logic [FLOAT_DATA_WIDTH-1:0]  squared_in,
  input  logic                         valid_in,
  input  logic                         pipeline_cleared,
  input  logic                         pair_ready,
  output logic [CORDIC_DATA_WIDTH-1:0] result_one,
  output logic [CORDIC_DATA_WIDTH-1:0] result_two,
  output logic [FLOAT_DATA_WIDTH-1:0]  sq_one,
  output logic [FLOAT_DATA_WIDTH-1:0]  sq_two,
  output logic                         pair_valid,
  output logic                         busy,
  output logic                         overrun,
  output logic                         orphan,
  output logic [15:0]                  pair_count
);

  localparam logic [1:0] WAIT_FIRST  = 2'b00;
  localparam logic [1:0] WAIT_SECOND = 2'b01;
  localparam logic [1:0] HOLD        = 2'b10;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       cap_one;
  logic       cap_two;
  logic       xfer;
  logic       drop;
  logic       orphan_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= WAIT_FIRST;
      result_one <= '0;
      result_two <= '0;
      sq_one     <= '0;
      sq_two     <= '0;
      overrun    <= 1'b0;
      orphan     <= 1'b0;
      pair_count <= 16'd0;
    end else if (clk_en) begin
      state  <= state_nxt;
      orphan <= orphan_nxt;
      if (cap_one) begin
        result_one <= result_in;
        sq_one     <= squared_in;
      end
      if (cap_two) begin
        result_two <= result_in;
        sq_two     <= squared_in;
      end
      if (xfer)
        pair_count <= pair_count + 16'd1;
      if (drop)
        overrun <= 1'b1;
    end
  end

  always_comb begin
    state_nxt  = state;
    cap_one    = 1'b0;
    cap_two    = 1'b0;
    xfer       = 1'b0;
    drop       = 1'b0;
    orphan_nxt = 1'b0;
    case (state)
      WAIT_FIRST: begin
        if (valid_in) begin
          cap_one   = 1'b1;
          state_nxt = WAIT_SECOND;
        end
      end
      WAIT_SECOND: begin
        if (valid_in) begin
          cap_two   = 1'b1;
          state_nxt = HOLD;
        end else if (pipeline_cleared) begin
          orphan_nxt = 1'b1;
          state_nxt  = WAIT_FIRST;
        end
      end
      HOLD: begin
        if (pair_ready) begin
          xfer = 1'b1;
          // a word arriving with the handoff starts the next pair
          if (valid_in) begin
            cap_one   = 1'b1;
            state_nxt = WAIT_SECOND;
          end else begin
            state_nxt = WAIT_FIRST;
          end
        end else if (valid_in) begin
          drop = 1'b1;
        end
      end
      default: state_nxt = WAIT_FIRST;
    endcase
  end

  always_comb begin
    pair_valid = (state == HOLD);
    busy       = (state == WAIT_SECOND) || (state == HOLD);
  end

endmodule

// File: tb/tb_cordic_pair_collector.sv
// Directed bench for cordic_pair_collector.
// Inputs change 1 time unit after each rising edge; outputs are sampled there.
module tb_cordic_pair_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic [21:0] result_in;
  logic [31:0] squared_in;
  logic        valid_in;
  logic        pipeline_cleared;
  logic        pair_ready;
  logic [21:0] result_one;
  logic [21:0] result_two;
  logic [31:0] sq_one;
  logic [31:0] sq_two;
  logic        pair_valid;
  logic        busy;
  logic        overrun;
  logic        orphan;
  logic [15:0] pair_count;

  int checks = 0;
  int errors = 0;

  cordic_pair_collector #(
    .CORDIC_DATA_WIDTH(22),
    .FLOAT_DATA_WIDTH(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .clk_en(clk_en),
    .result_in(result_in),
    .squared_in(squared_in),
    .valid_in(valid_in),
    .pipeline_cleared(pipeline_cleared),
    .pair_ready(pair_ready),
    .result_one(result_one),
    .result_two(result_two),
    .sq_one(sq_one),
    .sq_two(sq_two),
    .pair_valid(pair_valid),
    .busy(busy),
    .overrun(overrun),
    .orphan(orphan),
    .pair_count(pair_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [21:0] r, input logic [31:0] s);
    result_in  = r;
    squared_in = s;
    valid_in   = 1'b1;
    step();
    valid_in   = 1'b0;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_r1"}, 32'(result_one), 32'h0);
    chk({tag, "_r2"}, 32'(result_two), 32'h0);
    chk({tag, "_s1"}, sq_one, 32'h0);
    chk({tag, "_s2"}, sq_two, 32'h0);
    chk({tag, "_pv"}, 32'(pair_valid), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_ovr"}, 32'(overrun), 32'h0);
    chk({tag, "_orph"}, 32'(orphan), 32'h0);
    chk({tag, "_cnt"}, 32'(pair_count), 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    clk_en = 1'b1;
    result_in = '0;
    squared_in = '0;
    valid_in = 1'b0;
    pipeline_cleared = 1'b0;
    pair_ready = 1'b0;
    step();
    step();
    all_zero("reset");
    rst = 1'b0;

    // V1
    pair_ready = 1'b1;
    put(22'h00ABCD, 32'h3F800000);
    chk("v1_busy1", 32'(busy), 32'h1);
    chk("v1_pv1", 32'(pair_valid), 32'h0);
    chk("v1_r1", 32'(result_one), 32'h00ABCD);
    put(22'h012345, 32'h40000000);
    chk("v1_pv2", 32'(pair_valid), 32'h1);
    chk("v1_r1b", 32'(result_one), 32'h00ABCD);
    chk("v1_r2", 32'(result_two), 32'h012345);
    chk("v1_s1", sq_one, 32'h3F800000);
    chk("v1_s2", sq_two, 32'h40000000);
    step();
    chk("v1_cnt", 32'(pair_count), 32'h1);
    chk("v1_pv3", 32'(pair_valid), 32'h0);
    chk("v1_busy3", 32'(busy), 32'h0);

    // V2
    pair_ready = 1'b0;
    put(22'h000111, 32'h1);
    chk("v2_busy", 32'(busy), 32'h1);
    pipeline_cleared = 1'b1;
    step();
    pipeline_cleared = 1'b0;
    chk("v2_orph", 32'(orphan), 32'h1);
    chk("v2_busy2", 32'(busy), 32'h0);
    chk("v2_pv", 32'(pair_valid), 32'h0);
    chk("v2_cnt", 32'(pair_count), 32'h1);
    chk("v2_r1", 32'(result_one), 32'h000111);
    step();
    chk("v2_orph2", 32'(orphan), 32'h0);

    // V3
    put(22'h000AAA, 32'hA);
    put(22'h000BBB, 32'hB);
    chk("v3_pv", 32'(pair_valid), 32'h1);
    chk("v3_ovr0", 32'(overrun), 32'h0);
    put(22'h000222, 32'h2);
    chk("v3_ovr", 32'(overrun), 32'h1);
    chk("v3_pv2", 32'(pair_valid), 32'h1);
    chk("v3_r1", 32'(result_one), 32'h000AAA);
    chk("v3_r2", 32'(result_two), 32'h000BBB);
    chk("v3_s2", sq_two, 32'hB);
    pair_ready = 1'b1;
    step();
    pair_ready = 1'b0;
    chk("v3_cnt", 32'(pair_count), 32'h2);
    chk("v3_ovr2", 32'(overrun), 32'h1);
    chk("v3_busy", 32'(busy), 32'h0);

    // V4
    put(22'h000444, 32'h4);
    put(22'h000555, 32'h5);
    pair_ready = 1'b1;
    put(22'h000333, 32'h3);
    pair_ready = 1'b0;
    chk("v4_cnt", 32'(pair_count), 32'h3);
    chk("v4_r1", 32'(result_one), 32'h000333);
    chk("v4_busy", 32'(busy), 32'h1);
    chk("v4_pv", 32'(pair_valid), 32'h0);
    put(22'h000666, 32'h6);
    chk("v4_pv2", 32'(pair_valid), 32'h1);
    chk("v4_r2", 32'(result_two), 32'h000666);

    // V5: enable low freezes everything
    clk_en = 1'b0;
    pair_ready = 1'b1;
    pipeline_cleared = 1'b1;
    result_in = 22'h000777;
    squared_in = 32'h7;
    valid_in = 1'b1;
    step();
    step();
    step();
    chk("v5_pv", 32'(pair_valid), 32'h1);
    chk("v5_cnt", 32'(pair_count), 32'h3);
    chk("v5_r1", 32'(result_one), 32'h000333);
    chk("v5_r2", 32'(result_two), 32'h000666);
    valid_in = 1'b0;
    pipeline_cleared = 1'b0;
    clk_en = 1'b1;
    step();
    chk("v5_cnt4", 32'(pair_count), 32'h4);
    chk("v5_busy", 32'(busy), 32'h0);
    pair_ready = 1'b0;
    force dut.pair_count = 16'hFFFE;
    #1;
    release dut.pair_count;
    put(22'h1, 32'h1);
    put(22'h2, 32'h2);
    pair_ready = 1'b1;
    step();
    pair_ready = 1'b0;
    chk("v5_ffff", 32'(pair_count), 32'hFFFF);
    put(22'h3, 32'h3);
    put(22'h4, 32'h4);
    pair_ready = 1'b1;
    step();
    pair_ready = 1'b0;
    chk("v5_wrap", 32'(pair_count), 32'h0);

    // V6: async reset while holding
    put(22'h000888, 32'h8);
    put(22'h000999, 32'h9);
    chk("v6_pv", 32'(pair_valid), 32'h1);
    #3;
    rst = 1'b1;
    #1;
    all_zero("v6");
    step();
    chk("v6_orph", 32'(orphan), 32'h0);
    rst = 1'b0;
    put(22'h000ABC, 32'hC);
    chk("v6_first", 32'(result_one), 32'h000ABC);
    chk("v6_busy", 32'(busy), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
